// File: rtl/cache_scrub_pkg.sv
// Shared encodings for the cache ECC scrubber: store-port op codes and FSM states.
package cache_scrub_pkg;

  typedef enum logic [1:0] {
    OpRead      = 2'd0,
    OpWriteback = 2'd1,
    OpInval     = 2'd2
  } scrub_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWriteback,
    StInval,
    StNext
  } scrub_state_e;

endpackage

// File: rtl/scrub_sat_counter.sv
// Saturating up-counter: increments by one on inc, holds at all-ones, clears on reset.
module scrub_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_ecc_scrubber.sv
// Background ECC scrubber for one cache bank; walks lines through a spare store port.
// Define SCRUB_STATS_EN to build the corrected/double-fault error counters.
module cache_ecc_scrubber
  import cache_scrub_pkg::*;
#(
  parameter int unsigned CACHE_SIZE     = 16384,
  parameter int unsigned BANK_LINE_SIZE = 16,
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned SCRUB_INTERVAL = 1024,
  parameter int unsigned LINE_COUNT     = CACHE_SIZE / (NUM_BANKS * BANK_LINE_SIZE),
  parameter int unsigned LINE_BITS      = $clog2(LINE_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 scrub_req,
  output logic [1:0]           scrub_op,
  output logic [LINE_BITS-1:0] scrub_addr,
  input  logic                 scrub_gnt,
  input  logic                 rd_valid,
  input  logic                 rd_dirty,
  input  logic                 rd_corrected,
  input  logic                 rd_doublefault,
  input  logic                 pipe_wr_valid,
  input  logic [LINE_BITS-1:0] pipe_wr_addr,
  output logic                 fatal_err,
  output logic                 busy,
  output logic [15:0]          err_single_cnt,
  output logic [15:0]          err_double_cnt
);

  localparam int unsigned ICW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [ICW-1:0] IvalReload = ICW'(SCRUB_INTERVAL - 1);
  localparam logic [LINE_BITS-1:0] LastLine = LINE_BITS'(LINE_COUNT - 1);

  scrub_state_e         state_q, state_d;
  logic [LINE_BITS-1:0] addr_q, addr_d;
  logic [ICW-1:0]       ival_q, ival_d;
  logic                 fatal_q, fatal_d;
  scrub_op_e            op;
  logic                 conflict;
  logic                 read_gnt;

  assign conflict = pipe_wr_valid && (pipe_wr_addr == addr_q);
  assign read_gnt = (state_q == StRead) && scrub_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      ival_q  <= IvalReload;
      fatal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ival_q  <= ival_d;
      fatal_q <= fatal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ival_d    = ival_q;
    fatal_d   = 1'b0;
    scrub_req = 1'b0;
    op        = OpRead;
    case (state_q)
      StIdle: begin
        if (ival_q != '0) begin
          ival_d = ival_q - ICW'(1);
        end else if (enable) begin
          state_d = StRead;
        end
      end
      StRead: begin
        scrub_req = 1'b1;
        if (scrub_gnt) begin
          // Double fault outranks a corrected report on the same read.
          if (rd_valid && rd_doublefault) begin
            if (rd_dirty) begin
              fatal_d = 1'b1;
              state_d = StNext;
            end else begin
              state_d = StInval;
            end
          end else if (rd_valid && rd_corrected) begin
            state_d = StWriteback;
          end else begin
            state_d = StNext;
          end
        end
      end
      StWriteback, StInval: begin
        op = (state_q == StWriteback) ? OpWriteback : OpInval;
        // A pipe write to this line re-encodes it, so the repair is dropped even
        // in the would-be grant cycle.
        if (conflict) begin
          state_d = StNext;
        end else begin
          scrub_req = 1'b1;
          if (scrub_gnt) begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        addr_d  = (addr_q == LastLine) ? '0 : addr_q + LINE_BITS'(1);
        ival_d  = IvalReload;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign scrub_op   = op;
  assign scrub_addr = addr_q;
  assign fatal_err  = fatal_q;
  assign busy       = (state_q != StIdle);

`ifdef SCRUB_STATS_EN
  logic single_inc;
  logic double_inc;

  assign single_inc = read_gnt && rd_valid && rd_corrected && !rd_doublefault;
  assign double_inc = read_gnt && rd_valid && rd_doublefault;

  scrub_sat_counter #(
    .WIDTH(16)
  ) u_single_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (single_inc),
    .count(err_single_cnt)
  );

  scrub_sat_counter #(
    .WIDTH(16)
  ) u_double_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (double_inc),
    .count(err_double_cnt)
  );
`else
  logic unused_read_gnt;
  assign unused_read_gnt = read_gnt;
  assign err_single_cnt  = 16'h0000;
  assign err_double_cnt  = 16'h0000;
`endif

endmodule
